// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, trap/jump redirects with alignment
// checking, and an optional return-address stack enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
    parameter int               XLEN      = 64,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            JUMP,
    input  logic [XLEN-1:0] JUMP_PC,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic            ras_empty
);

    localparam int SH = $clog2(STEP);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q;
    logic            misalign_err_q, misalign_err_d;

    logic            adv_ok;
    logic            trap_bad;
    logic            jump_bad;
    logic            ras_avail;
    logic [XLEN-1:0] ras_top;
    logic            pop_take;
    logic            flush;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        misalign_err_d = 1'b0;
        pop_take       = 1'b0;
        flush          = 1'b0;
        adv_ok         = (state_q == RUN) && fetch_ready && !stall;
        trap_bad       = |trap_pc[SH-1:0];
        jump_bad       = |JUMP_PC[SH-1:0];

        // A trap is the only request honoured in every state.
        if (trap_valid) begin
            if (trap_bad) begin
                misalign_err_d = 1'b1;
                state_d        = HALT;
            end else begin
                pc_d    = trap_pc;
                state_d = RUN;
                flush   = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (JUMP) begin
                if (jump_bad) begin
                    misalign_err_d = 1'b1;
                    state_d        = HALT;
                end else begin
                    pc_d = JUMP_PC;
                end
            end else if (ras_pop && ras_avail && adv_ok) begin
                pc_d     = ras_top;
                pop_take = 1'b1;
            end else if (adv_ok) begin
                pc_d = pc_q + XLEN'(STEP);
            end
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VEC;
            pc_valid_q     <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pc_valid_q     <= (state_d == RUN);
            misalign_err_q <= misalign_err_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign misalign_err = misalign_err_q;

`ifdef PC_GEN_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [PW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   top_q, top_d;
    logic [PW-1:0]   ras_widx;
    logic            ras_we;
    logic            ras_empty_q;
    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];

    assign ras_avail = (cnt_q != '0);
    assign ras_top   = ras_mem_q[top_q];

    // Circular buffer: pushing past full wraps top onto the oldest slot.
    always_comb begin
        cnt_d    = cnt_q;
        top_d    = top_q;
        ras_we   = 1'b0;
        ras_widx = top_q;
        if (flush) begin
            cnt_d = '0;
        end else if (ras_push && pop_take) begin
            ras_we = 1'b1;
        end else if (ras_push) begin
            ras_we   = 1'b1;
            top_d    = top_q + PW'(1);
            ras_widx = top_q + PW'(1);
            if (cnt_q != (PW+1)'(RAS_DEPTH)) begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (pop_take) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            top_q       <= '0;
            ras_empty_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            top_q       <= top_d;
            ras_empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem_q[ras_widx] <= ras_push_addr;
        end
    end

    assign ras_empty = ras_empty_q;
`else
    logic unused_ras;

    assign ras_avail  = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{ras_push, ras_push_addr, ras_pop, pop_take, flush};
`endif

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 64: width of every address port and of pc.
REQ-002 Parameter RESET_VEC, default 0: value loaded into pc on reset.
REQ-003 Parameter STEP, default 4: sequential increment in bytes; power of two, at least 2.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 trap_valid  in  1  trap redirect request.
REQ-008 trap_pc  in  XLEN  trap target address.
REQ-009 JUMP  in  1  resolved branch/jump redirect request.
REQ-010 JUMP_PC  in  XLEN  branch/jump target address.
REQ-011 ras_push  in  1  call seen; push ras_push_addr.
REQ-012 ras_push_addr  in  XLEN  return address to push.
REQ-013 ras_pop  in  1  predicted return at fetch; redirect to top of stack.
REQ-014 stall  in  1  pipeline stall; blocks sequential advance only.
REQ-015 fetch_ready  in  1  fetch stage accepts pc this cycle.
REQ-016 pc  out  XLEN  current fetch address (register).
REQ-017 pc_valid  out  1  pc is presentable to fetch.
REQ-018 misalign_err  out  1  one-cycle pulse when a target is rejected as misaligned.
REQ-019 ras_empty  out  1  stack holds no entries.

Function
REQ-020 States: BOOT, RUN, HALT; pc_valid SHALL be 1 only in RUN.
REQ-021 BOOT SHALL last exactly one cycle after reset release, then go to RUN with pc unchanged.
REQ-022 In RUN, the next pc SHALL follow this priority: trap > JUMP > ras_pop (stack non-empty) > advance > hold.
REQ-023 Advance SHALL be pc + STEP, modulo 2^XLEN (0xFFFF_FFFF_FFFF_FFFC + 4 -> 0), and SHALL occur only when pc_valid && fetch_ready && !stall.
REQ-024 trap and JUMP SHALL be taken regardless of stall and fetch_ready; ras_pop SHALL be gated like advance.
REQ-025 A JUMP_PC or trap_pc whose log2(STEP) low bits are non-zero SHALL NOT load pc.
REQ-026 That rejection SHALL pulse misalign_err for one cycle and move the FSM to HALT.
REQ-027 HALT SHALL hold pc and ignore JUMP, ras_pop and advance; only an aligned trap_valid SHALL exit HALT, loading trap_pc and entering RUN.
REQ-028 trap_valid SHALL be honoured in BOOT: it loads trap_pc and enters RUN.
REQ-029 RAS: circular buffer with an occupancy count of 0..RAS_DEPTH.
REQ-030 Push when full SHALL overwrite the oldest entry; the count SHALL stay at RAS_DEPTH.
REQ-031 Pop when empty SHALL be ignored, and the cycle falls through to advance/hold.
REQ-032 Pop SHALL decrement the count only when the pop redirect is actually taken.
REQ-033 Simultaneous push and taken pop: pc SHALL load the old top, the push data SHALL replace that slot, and the count SHALL be unchanged.
REQ-034 An accepted trap SHALL flush the RAS (count 0) in the same cycle.
REQ-035 misalign_err SHALL be registered; no output SHALL depend combinationally on any input.

Reset
REQ-036 While rst is high: pc=RESET_VEC, state=BOOT, pc_valid=0, misalign_err=0, RAS count=0, ras_empty=1.
REQ-037 Reset asserted mid-operation SHALL override all pending requests immediately (asynchronously).

Configuration
REQ-038 Macro PC_GEN_RAS_EN: when defined, the RAS is built as specified above.
REQ-039 When PC_GEN_RAS_EN is not defined: no storage is built, ras_push and ras_pop are ignored, ras_empty is tied to 1, and all other behaviour is unchanged.

Verification
REQ-040 Reset with RESET_VEC=0x1000, then fetch_ready=1 and stall=0 -> pc_valid=0 for one cycle, then pc = 0x1000, 0x1004, 0x1008.
REQ-041 stall=1 with JUMP=1 and JUMP_PC=0x2000 in the same cycle -> pc=0x2000 next cycle; pc holds while stall stays high.
REQ-042 trap_valid=1 with trap_pc=0x80, JUMP=1 with JUMP_PC=0x40, and ras_pop=1 all in one cycle -> pc=0x80 and ras_empty=1.
REQ-043 JUMP_PC=0x2002 -> misalign_err pulses once, pc holds, pc_valid=0; a later JUMP is ignored; trap_pc=0x100 -> RUN with pc=0x100.
REQ-044 RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50, then pop five times -> pc sequence 0x50, 0x40, 0x30, 0x20; the fifth pop advances by STEP.
REQ-045 pc=0xFFFF_FFFF_FFFF_FFFC with advance -> pc=0; push 0x44 together with a pop while top=0x33 -> pc=0x33, new top=0x44, count unchanged.
